bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (pc_reg/if_id side) and the
//  mem stage's load/store port in the 5-stage pipeline. Grants one transaction at a time,
//  drives the bus, returns read data with a one-cycle ack, and raises per-requester stall
//  requests so the pipeline holds while its access is pending. Includes a wait-state watchdog.
// PARAMETERS
//  ADDR_W    32  address width, both requesters and bus
//  DATA_W    32  data width
//  MAX_WAIT  15  bus_ready_i wait cycles before abort (>=1); counter width = clog2(MAX_WAIT+1)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-low reset (0 = reset)
//  if_req_i       in   1       fetch request, held with if_addr_i until if_ack_o
//  if_addr_i      in   ADDR_W  fetch address (pc)
//  if_rdata_o     out  DATA_W  fetched instruction, valid when if_ack_o=1
//  if_ack_o       out  1       one-cycle fetch completion pulse
//  mem_req_i      in   1       data request, held with mem_* until mem_ack_o
//  mem_we_i       in   1       1 = store, 0 = load
//  mem_sel_i      in   4       byte lane enables
//  mem_addr_i     in   ADDR_W  data address
//  mem_wdata_i    in   DATA_W  store data
//  mem_rdata_o    out  DATA_W  load data, valid when mem_ack_o=1 (0 for stores)
//  mem_ack_o      out  1       one-cycle data completion pulse
//  bus_ce_o       out  1       bus access active
//  bus_we_o       out  1       bus write
//  bus_sel_o      out  4       bus byte enables (4'b1111 for fetch)
//  bus_addr_o     out  ADDR_W  bus address
//  bus_wdata_o    out  DATA_W  bus write data (0 for fetch/load)
//  bus_rdata_i    in   DATA_W  bus read data, sampled with bus_ready_i
//  bus_ready_i    in   1       slave completes current access this cycle
//  stallreq_if_o  out  1       comb: if_req_i & ~if_ack_o
//  stallreq_mem_o out  1       comb: mem_req_i & ~mem_ack_o
//  bus_err_o      out  1       one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=IF, wait_cnt=0; all registered outputs (bus_*, *_ack_o,
//    *_rdata_o, bus_err_o) = 0. Reset mid-access aborts immediately; no ack, no err.
//  - FSM states IDLE, GNT_IF, GNT_MEM. Bus outputs registered, loaded on grant, held
//    constant for the whole grant; bus_ce_o=1 exactly in GNT_IF/GNT_MEM.
//  - Grant decision (IDLE, or completion cycle of a grant): only one req -> that one;
//    both -> requester not equal to last_grant (round-robin); none -> IDLE.
//    A requester whose ack is being issued this cycle is not eligible for regrant.
//  - Completion: in GNT_x with bus_ready_i=1 -> next cycle x_ack_o=1, x_rdata_o=bus_rdata_i
//    (mem store: 0); last_grant<=x; back-to-back grant of the other requester allowed.
//  - Latency: req seen in cycle N (IDLE) -> bus_ce_o=1 in N+1; zero-wait slave gives ack in N+2.
//    Throughput with zero-wait slave and continuous reqs: one transaction per cycle pipelined
//    after first (grant of next loads in the same edge that issues ack).
//  - Watchdog: wait_cnt counts cycles in GNT_x with bus_ready_i=0, cleared on grant. At
//    wait_cnt==MAX_WAIT: drop bus_ce_o, x_ack_o=1 with x_rdata_o=0, bus_err_o=1, same cycle.
//  - Req dropped before ack (protocol violation): access still completes and acks; no abort.
//  - *_rdata_o hold last value between acks; acks never both high in one cycle.
// TESTING
//  1. Reset low mid GNT_MEM with bus_ready_i=0 -> all outputs 0 async, IDLE after release.
//  2. Only if_req_i, addr 0x0000_0040, ready same cycle as ce, rdata 0x3C01_1234 -> bus_ce_o
//     N+1, if_ack_o=1 N+2, if_rdata_o=0x3C01_1234, stallreq_if_o 1 in N,N+1, 0 in N+2.
//  3. Both req in same cycle after reset -> GNT_MEM first (last_grant=IF), then GNT_IF
//     back-to-back; mem_ack_o and if_ack_o in consecutive cycles, never together.
//  4. Store mem_sel_i=4'b0011, wdata 0xDEAD_BEEF, 3 wait states -> bus_we_o=1, sel/wdata held
//     4 cycles, mem_ack_o one cycle after ready, mem_rdata_o=0.
//  5. bus_ready_i stuck 0, MAX_WAIT=15 -> after 15 wait cycles: bus_err_o, if_ack_o pulse,
//     if_rdata_o=0, bus_ce_o=0; next pending req granted normally.
//  6. Continuous both reqs, zero-wait slave -> grants strictly alternate IF/MEM for 20 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between instruction fetch and the
// mem-stage load/store port. One transaction at a time, registered bus outputs, one-cycle
// acks and a wait-state watchdog that aborts a stuck access.
module bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  // Load/store requester
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  // Shared bus
  output logic              bus_ce_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ready_i,
  // Pipeline control
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_err_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  // Abort fires on the edge that ends the MAX_WAIT-th wait cycle
  localparam logic [CntW-1:0] AbortCnt = CntW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntMem} state_e;

  state_e            state_q;
  logic              last_grant_mem_q;  // 0 = fetch was granted last, 1 = mem
  logic [CntW-1:0]   wait_cnt_q;

  logic              if_ack_q, mem_ack_q, bus_err_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              bus_ce_q, bus_we_q;
  logic [3:0]        bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic in_gnt, done_if, done_mem, abort, decide;
  logic elig_if, elig_mem, grant_if, grant_mem;

  // Completion, abort and round-robin grant decision for the coming edge
  always_comb begin
    in_gnt   = (state_q != StIdle);
    done_if  = (state_q == StGntIf) && bus_ready_i;
    done_mem = (state_q == StGntMem) && bus_ready_i;
    abort    = in_gnt && !bus_ready_i && (wait_cnt_q == AbortCnt);
    decide   = (state_q == StIdle) || done_if || done_mem;
    // The requester being acked on this edge cannot be regranted on it
    elig_if   = if_req_i && !done_if;
    elig_mem  = mem_req_i && !done_mem;
    grant_if  = decide && elig_if && (!elig_mem || last_grant_mem_q);
    grant_mem = decide && elig_mem && (!elig_if || !last_grant_mem_q);
  end

  // Arbiter FSM with registered bus, ack, read-data and error outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      last_grant_mem_q <= 1'b0;
      wait_cnt_q       <= '0;
      if_ack_q         <= 1'b0;
      mem_ack_q        <= 1'b0;
      bus_err_q        <= 1'b0;
      if_rdata_q       <= '0;
      mem_rdata_q      <= '0;
      bus_ce_q         <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_sel_q        <= '0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      bus_err_q <= 1'b0;

      if (done_if) begin
        if_ack_q         <= 1'b1;
        if_rdata_q       <= bus_rdata_i;
        last_grant_mem_q <= 1'b0;
      end
      if (done_mem) begin
        mem_ack_q        <= 1'b1;
        mem_rdata_q      <= bus_we_q ? '0 : bus_rdata_i;
        last_grant_mem_q <= 1'b1;
      end
      if (abort) begin
        bus_err_q <= 1'b1;
        if (state_q == StGntIf) begin
          if_ack_q         <= 1'b1;
          if_rdata_q       <= '0;
          last_grant_mem_q <= 1'b0;
        end else begin
          mem_ack_q        <= 1'b1;
          mem_rdata_q      <= '0;
          last_grant_mem_q <= 1'b1;
        end
      end

      if (grant_if) begin
        state_q     <= StGntIf;
        bus_ce_q    <= 1'b1;
        bus_we_q    <= 1'b0;
        bus_sel_q   <= 4'b1111;
        bus_addr_q  <= if_addr_i;
        bus_wdata_q <= '0;
        wait_cnt_q  <= '0;
      end else if (grant_mem) begin
        state_q     <= StGntMem;
        bus_ce_q    <= 1'b1;
        bus_we_q    <= mem_we_i;
        bus_sel_q   <= mem_sel_i;
        bus_addr_q  <= mem_addr_i;
        bus_wdata_q <= mem_we_i ? mem_wdata_i : '0;
        wait_cnt_q  <= '0;
      end else if (decide || abort) begin
        // Nothing to grant, or watchdog fired: release the bus
        state_q     <= StIdle;
        bus_ce_q    <= 1'b0;
        bus_we_q    <= 1'b0;
        bus_sel_q   <= '0;
        bus_addr_q  <= '0;
        bus_wdata_q <= '0;
        wait_cnt_q  <= '0;
      end else if (in_gnt) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign if_ack_o       = if_ack_q;
  assign mem_ack_o      = mem_ack_q;
  assign bus_err_o      = bus_err_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign bus_ce_o       = bus_ce_q;
  assign bus_we_o       = bus_we_q;
  assign bus_sel_o      = bus_sel_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign stallreq_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, single fetch, arbitration order,
// wait-stated store, watchdog abort and sustained alternating throughput.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ready_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_ack_o       (if_ack_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ack_o      (mem_ack_o),
    .bus_ce_o       (bus_ce_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ready_i    (bus_ready_i),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_err_o      (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_sel_i   = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    bus_rdata_i = '0;
    bus_ready_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus_ce_o, if_ack_o, mem_ack_o, bus_err_o} !== 4'b0)
      $display("FAIL reset_ctl: got ce/ia/ma/err=%b want 0000",
               {bus_ce_o, if_ack_o, mem_ack_o, bus_err_o});
    else pass_cnt++;
    total_cnt++;
    if ({if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o} !== 128'b0)
      $display("FAIL reset_data: got nonzero data/addr outputs");
    else pass_cnt++;
    rst = 1'b1;
    // Load pending with no ready, then reset mid-grant
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0200;
    mem_sel_i  = 4'b1111;
    tick();
    tick();
    total_cnt++;
    if (bus_ce_o !== 1'b1) $display("FAIL reset_pre_ce: got %b want 1", bus_ce_o);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, mem_ack_o, bus_err_o} !== 8'b0 || bus_addr_o !== 32'h0)
      $display("FAIL reset_async: got ce=%b sel=%h addr=%h ack=%b err=%b want all 0",
               bus_ce_o, bus_sel_o, bus_addr_o, mem_ack_o, bus_err_o);
    else pass_cnt++;
    mem_req_i = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({bus_ce_o, mem_ack_o, bus_err_o} !== 3'b0)
      $display("FAIL reset_idle: got ce/ack/err=%b want 000", {bus_ce_o, mem_ack_o, bus_err_o});
    else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0040;
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h3C01_1234;
    #1;
    total_cnt++;
    if (stallreq_if_o !== 1'b1) $display("FAIL fetch_stall_n: got %b want 1", stallreq_if_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h40 || bus_sel_o !== 4'hF || bus_we_o !== 1'b0)
      $display("FAIL fetch_bus: got ce=%b addr=%h sel=%h we=%b want 1 00000040 f 0",
               bus_ce_o, bus_addr_o, bus_sel_o, bus_we_o);
    else pass_cnt++;
    total_cnt++;
    if (if_ack_o !== 1'b0 || stallreq_if_o !== 1'b1)
      $display("FAIL fetch_n1: got ack=%b stall=%b want 0 1", if_ack_o, stallreq_if_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h3C01_1234)
      $display("FAIL fetch_ack: got ack=%b rdata=%h want 1 3c011234", if_ack_o, if_rdata_o);
    else pass_cnt++;
    total_cnt++;
    if (stallreq_if_o !== 1'b0 || bus_ce_o !== 1'b0)
      $display("FAIL fetch_n2: got stall=%b ce=%b want 0 0", stallreq_if_o, bus_ce_o);
    else pass_cnt++;
    if_req_i    = 1'b0;
    bus_rdata_i = 32'hFFFF_0000;
    tick();
    total_cnt++;
    if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h3C01_1234)
      $display("FAIL fetch_hold: got ack=%b rdata=%h want 0 3c011234", if_ack_o, if_rdata_o);
    else pass_cnt++;
  endtask

  task automatic test_both_req();
    do_reset();
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0100;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'b1111;
    mem_addr_i  = 32'h0000_0200;
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h1111_2222;
    tick();
    total_cnt++;
    if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h200)
      $display("FAIL both_first: got ce=%b addr=%h want 1 00000200", bus_ce_o, bus_addr_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_ack_o !== 1'b1 || if_ack_o !== 1'b0 || mem_rdata_o !== 32'h1111_2222)
      $display("FAIL both_mem_ack: got ma=%b ia=%b rdata=%h want 1 0 11112222",
               mem_ack_o, if_ack_o, mem_rdata_o);
    else pass_cnt++;
    total_cnt++;
    if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h100)
      $display("FAIL both_b2b: got ce=%b addr=%h want 1 00000100", bus_ce_o, bus_addr_o);
    else pass_cnt++;
    mem_req_i   = 1'b0;
    bus_rdata_i = 32'h3333_4444;
    tick();
    total_cnt++;
    if (if_ack_o !== 1'b1 || mem_ack_o !== 1'b0 || if_rdata_o !== 32'h3333_4444)
      $display("FAIL both_if_ack: got ia=%b ma=%b rdata=%h want 1 0 33334444",
               if_ack_o, mem_ack_o, if_rdata_o);
    else pass_cnt++;
    if_req_i = 1'b0;
    tick();
    total_cnt++;
    if ({if_ack_o, mem_ack_o, bus_ce_o} !== 3'b0)
      $display("FAIL both_idle: got ia/ma/ce=%b want 000", {if_ack_o, mem_ack_o, bus_ce_o});
    else pass_cnt++;
  endtask

  task automatic test_store_wait();
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_sel_i   = 4'b0011;
    mem_addr_i  = 32'h0000_0300;
    mem_wdata_i = 32'hDEAD_BEEF;
    bus_ready_i = 1'b0;
    bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (bus_ce_o !== 1'b1 || bus_we_o !== 1'b1 || bus_sel_o !== 4'b0011 ||
          bus_wdata_o !== 32'hDEAD_BEEF || bus_addr_o !== 32'h300 || mem_ack_o !== 1'b0)
        $display("FAIL store_hold%0d: got ce=%b we=%b sel=%b wdata=%h ack=%b want 1 1 0011 deadbeef 0",
                 i, bus_ce_o, bus_we_o, bus_sel_o, bus_wdata_o, mem_ack_o);
      else pass_cnt++;
      if (i == 3) bus_ready_i = 1'b1;
      tick();
    end
    total_cnt++;
    if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h0 || bus_ce_o !== 1'b0)
      $display("FAIL store_ack: got ack=%b rdata=%h ce=%b want 1 00000000 0",
               mem_ack_o, mem_rdata_o, bus_ce_o);
    else pass_cnt++;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
  endtask

  task automatic test_watchdog();
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0500;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'b1111;
    mem_addr_i  = 32'h0000_0600;
    bus_ready_i = 1'b0;
    bus_rdata_i = 32'hBAD0_BAD0;
    tick();
    total_cnt++;
    if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h500)
      $display("FAIL wd_grant: got ce=%b addr=%h want 1 00000500", bus_ce_o, bus_addr_o);
    else pass_cnt++;
    for (int i = 1; i < 15; i++) begin
      tick();
      total_cnt++;
      if (bus_ce_o !== 1'b1 || bus_err_o !== 1'b0 || if_ack_o !== 1'b0)
        $display("FAIL wd_wait%0d: got ce=%b err=%b ack=%b want 1 0 0",
                 i, bus_ce_o, bus_err_o, if_ack_o);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (bus_err_o !== 1'b1 || if_ack_o !== 1'b1 || if_rdata_o !== 32'h0 ||
        bus_ce_o !== 1'b0 || mem_ack_o !== 1'b0)
      $display("FAIL wd_abort: got err=%b ia=%b rdata=%h ce=%b ma=%b want 1 1 0 0 0",
               bus_err_o, if_ack_o, if_rdata_o, bus_ce_o, mem_ack_o);
    else pass_cnt++;
    if_req_i    = 1'b0;
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h7777_8888;
    tick();
    total_cnt++;
    if (bus_ce_o !== 1'b1 || bus_addr_o !== 32'h600 || bus_err_o !== 1'b0)
      $display("FAIL wd_next_grant: got ce=%b addr=%h err=%b want 1 00000600 0",
               bus_ce_o, bus_addr_o, bus_err_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h7777_8888 || bus_err_o !== 1'b0)
      $display("FAIL wd_next_ack: got ack=%b rdata=%h err=%b want 1 77778888 0",
               mem_ack_o, mem_rdata_o, bus_err_o);
    else pass_cnt++;
    mem_req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_mem;
    do_reset();
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0A00;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'b1111;
    mem_addr_i  = 32'h0000_0B00;
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h0000_5555;
    tick();
    total_cnt++;
    if (bus_addr_o !== 32'hB00) $display("FAIL b2b_first: got addr=%h want 00000b00", bus_addr_o);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_mem = (k % 2 == 0);
      total_cnt++;
      if (mem_ack_o !== exp_mem || if_ack_o !== !exp_mem || bus_ce_o !== 1'b1 ||
          bus_addr_o !== (exp_mem ? 32'hA00 : 32'hB00))
        $display("FAIL b2b_%0d: got ma=%b ia=%b ce=%b addr=%h want %b %b 1 %h", k, mem_ack_o,
                 if_ack_o, bus_ce_o, bus_addr_o, exp_mem, !exp_mem,
                 exp_mem ? 32'hA00 : 32'hB00);
      else pass_cnt++;
    end
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({bus_ce_o, if_ack_o, mem_ack_o} !== 3'b0)
      $display("FAIL b2b_idle: got ce/ia/ma=%b want 000", {bus_ce_o, if_ack_o, mem_ack_o});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_both_req();
    test_store_wait();
    test_watchdog();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
